// File: rtl/bru_pkg.sv
// Shared types and MIPS decode constants for the branch resolver slice.
package bru_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pred_pc;
    } pred_entry_t;

    typedef enum logic {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } bru_state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;

    function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
        return pc4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/pred_queue.sv
// In-order FIFO of outstanding predictions; flush resets both pointers.
module pred_queue
    import bru_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  pred_entry_t push_data,
    output pred_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    pred_entry_t r_mem [DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        w_do_pop;
    logic        w_do_push;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign head      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full queue still accepts a push.
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// Resolves queued next-PC predictions, emits predictor training and redirect.
// Optional statistics counters are enabled with BRU_STATS_EN.
module branch_resolver
    import bru_pkg::*;
#(
`ifdef BRU_STATS_EN
    parameter int unsigned CNT_W = 32,
`endif
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             push_valid,
    input  logic [31:0]      push_pc,
    input  logic [31:0]      push_pred_pc,
    output logic             full,
    input  logic             res_valid,
    input  logic [31:0]      res_pc,
    input  logic [31:0]      res_instr,
    input  logic [31:0]      res_rs,
    input  logic [31:0]      res_rt,
    output logic             miss,
    output logic [31:0]      last_pc,
    output logic [31:0]      last_instr,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
`ifdef BRU_STATS_EN
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_misses,
    output logic [CNT_W-1:0] stat_redirects,
`endif
    output logic             order_err
);

    bru_state_t  r_state;
    bru_state_t  w_state_next;
    pred_entry_t w_head;
    pred_entry_t w_push_data;
    logic        w_full;
    logic        w_empty;
    logic [5:0]  w_opcode;
    logic [31:0] w_pc4;
    logic [31:0] w_next;
    logic        w_cond;
    logic        w_taken;
    logic        w_run;
    logic        w_resolve_ok;
    logic        w_bad_res;
    logic        w_mismatch;
    logic        w_pred_taken;
    logic        w_miss_d;
    logic        r_miss;
    logic [31:0] r_last_pc;
    logic [31:0] r_last_instr;
    logic [31:0] r_redirect_pc;
    logic        r_order_err;

    assign w_opcode     = res_instr[31:26];
    assign w_pc4        = res_pc + 32'd4;
    assign w_run        = en && (r_state == RUN);
    assign w_resolve_ok = w_run && res_valid && !w_empty && (res_pc == w_head.pc);
    assign w_bad_res    = w_run && res_valid && (w_empty || (res_pc != w_head.pc));
    assign w_mismatch   = w_resolve_ok && (w_next != w_head.pred_pc);
    assign w_pred_taken = (w_head.pred_pc != w_pc4);
    assign w_miss_d     = w_resolve_ok && w_cond && (w_taken != w_pred_taken);
    assign w_push_data  = '{pc: push_pc, pred_pc: push_pred_pc};

    always_comb begin
        w_cond  = 1'b0;
        w_taken = 1'b0;
        w_next  = w_pc4;
        case (w_opcode)
            OP_BEQ:  begin w_cond = 1'b1; w_taken = (res_rs == res_rt); end
            OP_BNE:  begin w_cond = 1'b1; w_taken = (res_rs != res_rt); end
            OP_BLEZ: begin w_cond = 1'b1; w_taken = ($signed(res_rs) <= 0); end
            OP_BGTZ: begin w_cond = 1'b1; w_taken = ($signed(res_rs) > 0); end
            OP_REGIMM: begin
                if (res_instr[20:16] == RT_BLTZ) begin
                    w_cond  = 1'b1;
                    w_taken = res_rs[31];
                end else if (res_instr[20:16] == RT_BGEZ) begin
                    w_cond  = 1'b1;
                    w_taken = !res_rs[31];
                end
            end
            OP_J, OP_JAL: w_next = {w_pc4[31:28], res_instr[25:0], 2'b00};
            OP_SPECIAL: begin
                if (res_instr[5:0] == FN_JR || res_instr[5:0] == FN_JALR) w_next = res_rs;
            end
            default: ;
        endcase
        if (w_cond && w_taken) w_next = branch_target(w_pc4, res_instr[15:0]);
    end

    // Pushes younger than a mispredict are dropped together with the flush.
    pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (w_run && push_valid && !w_mismatch),
        .pop       (w_resolve_ok),
        .flush     (w_mismatch),
        .push_data (w_push_data),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)   r_state <= RUN;
        else if (en) r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            RUN:     if (w_mismatch) w_state_next = RECOVER;
            RECOVER: w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_comb begin
        redirect = (r_state == RECOVER);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_miss        <= 1'b0;
            r_last_pc     <= '0;
            r_last_instr  <= '0;
            r_redirect_pc <= '0;
            r_order_err   <= 1'b0;
        end else if (en) begin
            r_miss       <= w_miss_d;
            r_last_instr <= w_resolve_ok ? res_instr : '0;
            if (w_resolve_ok) r_last_pc     <= res_pc;
            if (w_mismatch)   r_redirect_pc <= w_next;
            if (w_bad_res)    r_order_err   <= 1'b1;
        end
    end

    assign full        = w_full;
    assign miss        = r_miss;
    assign last_pc     = r_last_pc;
    assign last_instr  = r_last_instr;
    assign redirect_pc = r_redirect_pc;
    assign order_err   = r_order_err;

`ifdef BRU_STATS_EN
    logic [CNT_W-1:0] r_stat_branches;
    logic [CNT_W-1:0] r_stat_misses;
    logic [CNT_W-1:0] r_stat_redirects;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_branches  <= '0;
            r_stat_misses    <= '0;
            r_stat_redirects <= '0;
        end else begin
            if (w_resolve_ok && w_cond && r_stat_branches != '1)
                r_stat_branches <= r_stat_branches + 1'b1;
            if (w_miss_d && r_stat_misses != '1)
                r_stat_misses <= r_stat_misses + 1'b1;
            if (w_mismatch && r_stat_redirects != '1)
                r_stat_redirects <= r_stat_redirects + 1'b1;
        end
    end

    assign stat_branches  = r_stat_branches;
    assign stat_misses    = r_stat_misses;
    assign stat_redirects = r_stat_redirects;
`endif

endmodule
